// File: rtl/sop_pkg.sv
// sop_pkg: shared types and widths for the sum-of-products sequencer.
//   state_t : FSM states IDLE, MUL_AB, MUL_CD, ADD, DONE
//   OP_W/PROD_W/SUM_W/RES_W : operand, product, sum and result widths
package sop_pkg;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int SUM_W  = 9;
  localparam int RES_W  = 12;

  typedef enum logic [2:0] {IDLE, MUL_AB, MUL_CD, ADD, DONE} state_t;
endpackage

// File: rtl/sop_sequencer_if.sv
// sop_sequencer_if: operand/handshake bundle between capture logic and display path.
//   master : drives start, a, b, c, d, acc_clr; observes busy, done, result
//   slave  : the sequencer side
interface sop_sequencer_if;
  import sop_pkg::*;
  logic             start;
  logic [OP_W-1:0]  a, b, c, d;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;

  modport master (output start, a, b, c, d, acc_clr, input busy, done, result);
  modport slave  (input start, a, b, c, d, acc_clr, output busy, done, result);
endinterface

// File: rtl/sop_datapath.sv
// sop_datapath: time-multiplexed datapath for P = A*B + C*D.
//   sop_mul4x4   : combinational 4x4 unsigned array multiplier
//   sop_datapath : operand mux, shared multiplier, p1/p2 registers, 8-bit ripple adder
//     clk, rst_n     : clock, async active-low reset
//     sel_cd         : 0 selects (a_r,b_r), 1 selects (c_r,d_r)
//     ld_p1, ld_p2   : load product into p1 / p2
//     a_r..d_r       : registered operands
//     sum            : p1 + p2 with carry-out in bit 8
module sop_mul4x4 import sop_pkg::*; (
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] p
);
  logic [OP_W-1:0][PROD_W-1:0] pp;
  logic [OP_W-1:0][PROD_W-1:0] row;

  // One shifted partial-product row per multiplier bit, summed row by row.
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = PROD_W'(x & {OP_W{y[i]}}) << i;
    if (i == 0) begin : g_first
      assign row[i] = pp[i];
    end else begin : g_acc
      assign row[i] = row[i-1] + pp[i];
    end
  end
  assign p = row[OP_W-1];
endmodule

module sop_datapath import sop_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel_cd,
  input  logic             ld_p1,
  input  logic             ld_p2,
  input  logic [OP_W-1:0]  a_r,
  input  logic [OP_W-1:0]  b_r,
  input  logic [OP_W-1:0]  c_r,
  input  logic [OP_W-1:0]  d_r,
  output logic [SUM_W-1:0] sum
);
  logic [OP_W-1:0]   mx, my;
  logic [PROD_W-1:0] prod, p1, p2, s;
  logic [PROD_W:0]   cy;

  assign mx = sel_cd ? c_r : a_r;
  assign my = sel_cd ? d_r : b_r;

  sop_mul4x4 u_mul (.x(mx), .y(my), .p(prod));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      if (ld_p1) p1 <= prod;
      if (ld_p2) p2 <= prod;
    end
  end

  assign cy[0] = 1'b0;
  for (genvar i = 0; i < PROD_W; i++) begin : g_fa
    assign s[i]    = p1[i] ^ p2[i] ^ cy[i];
    assign cy[i+1] = (p1[i] & p2[i]) | (cy[i] & (p1[i] ^ p2[i]));
  end
  assign sum = {cy[PROD_W], s};
endmodule

// File: rtl/sop_sequencer.sv
// sop_sequencer: 4-cycle controller computing A*B + C*D on one shared multiplier.
//   clk, rst_n : clock, async active-low reset
//   bus        : sop_sequencer_if.slave (start, a..d, acc_clr in; busy, done, result out)
// Optional feature: define SOP_ACCUM_EN to add a 12-bit wrapping accumulator;
// result then reports the running total and acc_clr (in IDLE/DONE) zeroes it.
module sop_sequencer import sop_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  sop_sequencer_if.slave bus
);
  state_t           state, nxt;
  logic             idle_or_done, accept;
  logic [OP_W-1:0]  a_r, b_r, c_r, d_r;
  logic [SUM_W-1:0] sum;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign accept       = bus.start && idle_or_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = MUL_AB;
      MUL_AB:  nxt = MUL_CD;
      MUL_CD:  nxt = ADD;
      ADD:     nxt = DONE;
      DONE:    nxt = bus.start ? MUL_AB : IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == MUL_AB) || (state == MUL_CD) || (state == ADD);
  assign bus.done = (state == DONE);

  // Operands are frozen for the whole operation; the datapath never sees live inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0;
    end else if (accept) begin
      a_r <= bus.a; b_r <= bus.b; c_r <= bus.c; d_r <= bus.d;
    end
  end

  sop_datapath u_dp (
    .clk   (clk),
    .rst_n (rst_n),
    .sel_cd(state == MUL_CD),
    .ld_p1 (state == MUL_AB),
    .ld_p2 (state == MUL_CD),
    .a_r   (a_r),
    .b_r   (b_r),
    .c_r   (c_r),
    .d_r   (d_r),
    .sum   (sum)
  );

`ifdef SOP_ACCUM_EN
  logic [RES_W-1:0] acc;

  // Clear only happens outside ADD, so it never collides with an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      bus.result <= '0;
    end else if (idle_or_done && bus.acc_clr) begin
      acc <= '0;
    end else if (state == ADD) begin
      acc        <= acc + RES_W'(sum);
      bus.result <= acc + RES_W'(sum);
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             bus.result <= '0;
    else if (state == ADD)  bus.result <= RES_W'(sum);
  end
`endif
endmodule

// File: tb/tb_sop_sequencer.sv
// tb_sop_sequencer: self-checking bench for sop_sequencer.
// Reference model: an operation accepted at edge k finishes at edge k+3 with
// a*b+c*d (or the wrapped running total when SOP_ACCUM_EN is defined); a new
// start is only accepted from edge k+4 on.
module tb_sop_sequencer;
  import sop_pkg::*;

`ifdef SOP_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sop_sequencer_if bus();
  sop_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  // model state
  int cyc = 0;
  bit have_op = 1'b0;
  int t_acc = 0;
  int pending = 0;
  int res_m = 0;
  int acc_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit s, input int a, input int b, input int c, input int d,
                            input bit clr);
    cyc++;
    if (have_op && cyc == t_acc + 3) begin
      if (ACC) begin
        acc_m = (acc_m + pending) % 4096;
        res_m = acc_m;
      end else begin
        res_m = pending;
      end
    end
    if (!have_op || cyc >= t_acc + 4) begin
      if (ACC && clr) acc_m = 0;
      if (s) begin
        have_op = 1'b1;
        t_acc   = cyc;
        pending = a * b + c * d;
      end
    end
  endtask

  // Drive at the negedge, clock once, check at the following negedge.
  task automatic step(input bit s, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d, input bit clr);
    bus.start = s; bus.a = a; bus.b = b; bus.c = c; bus.d = d; bus.acc_clr = clr;
    @(posedge clk);
    model_edge(s, int'(a), int'(b), int'(c), int'(d), clr);
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(have_op && cyc < t_acc + 3));
    chk("done", 32'(bus.done), 32'(have_op && cyc == t_acc + 3));
    chk("result", 32'(bus.result), 32'(res_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    have_op = 1'b0; res_m = 0; acc_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full operation from a clean reset; checks the known result on the done cycle.
  task automatic op_chk(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d, input int exp);
    do_reset();
    step(1'b1, a, b, c, d, 1'b0);
    idle(3);
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk(tag, 32'(bus.result), 32'(exp));
    idle(1);
  endtask

  int dones;

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.acc_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("init_busy", 32'(bus.busy), 32'd0);
    chk("init_done", 32'(bus.done), 32'd0);
    chk("init_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;
    idle(2);

    op_chk("r42", 4'd3, 4'd4, 4'd5, 4'd6, 42);
    op_chk("r450", 4'd15, 4'd15, 4'd15, 4'd15, 450);
    op_chk("r0", 4'd0, 4'd0, 4'd0, 4'd0, 0);

    // starts and operand changes while busy are ignored
    do_reset();
    step(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    step(1'b1, 4'd15, 4'd15, 4'd15, 4'd15, 1'b0);
    step(1'b1, 4'd7, 4'd7, 4'd7, 4'd7, 1'b0);
    step(1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_result", 32'(bus.result), 32'd14);
    idle(4);

    // start held: one result every 4 cycles
    do_reset();
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'd2, 4'd3, 4'd1, 4'd1, 1'b0);
      if (bus.done) dones++;
      if (i % 4 == 3) chk("hold_result", 32'(bus.result), 32'd7);
    end
    chk("hold_dones", 32'(dones), 32'd3);
    idle(4);

    // reset in MUL_CD aborts, next op completes
    do_reset();
    step(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    do_reset();
    idle(4);
    step(1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0);
    idle(3);
    chk("after_rst", 32'(bus.result), 32'd42);
    idle(1);

`ifdef SOP_ACCUM_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd15, 4'd15, 4'd15, 4'd15, i == 0);
      idle(3);
      chk("acc_run", 32'(bus.result), 32'((450 * (i + 1)) % 4096));
    end
    chk("acc_wrap", 32'(bus.result), 32'h194);
    idle(1);
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b1, 4'd3, 4'd4, 4'd5, 4'd6, 1'b0);
    idle(3);
    chk("acc_clr", 32'(bus.result), 32'd42);
`endif

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(2) == 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
